// File: rtl/tbuf.sv
// tbuf: tristate fabric driver. Drives `a` onto `f` while enabled. REG_OUT
// selects a direct combinational path or a registered data/enable path.
// Also reports the applied enable and the last value actually driven.
module tbuf #(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1'b0
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [WIDTH-1:0] a,
  input  logic             b,
  output tri   [WIDTH-1:0] f,
  output logic             oe,
  output logic [WIDTH-1:0] last_q
);

  // Value presented to the pad while oe is high
  logic [WIDTH-1:0] drv;
  logic [WIDTH-1:0] last_d;

  generate
    if (REG_OUT) begin : g_reg
      logic [WIDTH-1:0] a_q, a_d;
      logic             en_q, en_d;

      // Capture data and enable every cycle
      always_comb begin
        a_d  = a;
        en_d = b;
      end

      // Data/enable registers; reset releases the net immediately
      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
          a_q  <= '0;
          en_q <= 1'b0;
        end else begin
          a_q  <= a_d;
          en_q <= en_d;
        end
      end

      assign drv = a_q;
      assign oe  = en_q;
    end else begin : g_comb
      // Pure wire path: reset has no say over the drive here
      assign drv = a;
      assign oe  = b;
    end
  endgenerate

  // Single shared enable for every bit; x/z on data passes through untouched
  assign f = oe ? drv : {WIDTH{1'bz}};

  // Remember what was on the net at this edge, only if it was being driven
  always_comb begin
    last_d = oe ? drv : last_q;
  end

  // Diagnostic capture of the last driven value
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) last_q <= '0;
    else       last_q <= last_d;
  end

endmodule

// File: tb/tb_tbuf.sv
// Bench for tbuf: directed combinational checks plus a randomized registered
// stream scored against a history-based model through an expectation queue.
module tb_tbuf;

  typedef struct {
    logic [7:0] f;
    logic       oe;
    logic [7:0] last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Combinational WIDTH=1
  logic c1_nrst, c1_a, c1_b, c1_oe, c1_last;
  wire  c1_f;
  tbuf #(.WIDTH(1), .REG_OUT(1'b0)) u_c1 (
    .clk(clk), .nrst(c1_nrst), .a(c1_a), .b(c1_b),
    .f(c1_f), .oe(c1_oe), .last_q(c1_last));

  // Combinational WIDTH=8
  logic       c8_nrst, c8_b, c8_oe;
  logic [7:0] c8_a, c8_last;
  wire  [7:0] c8_f;
  tbuf #(.WIDTH(8), .REG_OUT(1'b0)) u_c8 (
    .clk(clk), .nrst(c8_nrst), .a(c8_a), .b(c8_b),
    .f(c8_f), .oe(c8_oe), .last_q(c8_last));

  // Registered WIDTH=8
  logic       r_nrst, r_b, r_oe;
  logic [7:0] r_a, r_last;
  wire  [7:0] r_f;
  tbuf #(.WIDTH(8), .REG_OUT(1'b1)) u_r8 (
    .clk(clk), .nrst(r_nrst), .a(r_a), .b(r_b),
    .f(r_f), .oe(r_oe), .last_q(r_last));

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- registered-mode reference model ----------------
  // hist_a/hist_b[k] = inputs present at the k-th edge since reset.
  logic [7:0] hist_a[$];
  logic       hist_b[$];
  exp_t       sb[$];

  // After edge n the net shows input n if it was enabled; last is the newest
  // enabled input strictly older than n (it was on the net during an edge).
  function automatic exp_t model();
    exp_t e;
    int n = hist_a.size() - 1;
    e.f    = 8'hzz;
    e.oe   = 1'b0;
    e.last = 8'h00;
    if (n >= 0) begin
      e.oe = hist_b[n];
      if (hist_b[n]) e.f = hist_a[n];
      for (int k = n - 1; k >= 0; k--) begin
        if (hist_b[k]) begin
          e.last = hist_a[k];
          break;
        end
      end
    end
    return e;
  endfunction

  // Monitor: compare against the queued expectation shortly after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("reg_f",    r_f,          e.f);
        chk("reg_oe",   {7'b0, r_oe}, {7'b0, e.oe});
        chk("reg_last", r_last,       e.last);
      end
    end
  end

  // One cycle of registered stimulus: inputs set mid-cycle, expectation queued at the edge
  task automatic step(input logic [7:0] av, input logic bv, input bit rel);
    exp_t pre;
    @(negedge clk);
    pre = model();
    if (rel) r_nrst = 1'b1;
    r_a = av;
    r_b = bv;
    hist_a.push_back(av);
    hist_b.push_back(bv);
    #1;
    // Before the edge nothing new may be visible yet
    chk("reg_pre_f",  r_f,          pre.f);
    chk("reg_pre_oe", {7'b0, r_oe}, {7'b0, pre.oe});
    @(posedge clk);
    sb.push_back(model());
  endtask

  task automatic async_reset();
    @(negedge clk);
    r_nrst = 1'b0;
    #1;
    chk("rst_f",    r_f,          8'hzz);
    chk("rst_oe",   {7'b0, r_oe}, 8'h00);
    chk("rst_last", r_last,       8'h00);
    hist_a.delete();
    hist_b.delete();
  endtask

  task automatic reg_tests();
    r_nrst = 1'b0; r_a = 8'h00; r_b = 1'b0;
    #2;
    chk("init_f",    r_f,          8'hzz);
    chk("init_oe",   {7'b0, r_oe}, 8'h00);
    chk("init_last", r_last,       8'h00);
    // Directed: enable with a=1, hold, then drop enable
    step(8'h01, 1'b1, 1'b1);
    step(8'h01, 1'b1, 1'b0);
    step(8'h01, 1'b0, 1'b0);
    step(8'h5A, 1'b0, 1'b0);
    // Reset mid-drive, then release driving zero
    step(8'hC3, 1'b1, 1'b0);
    step(8'h3C, 1'b1, 1'b0);
    async_reset();
    step(8'h00, 1'b1, 1'b1);
    step(8'hFF, 1'b1, 1'b0);
    // Randomized stream with occasional resets
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        async_reset();
        step(8'($urandom), 1'($urandom), 1'b1);
      end else begin
        step(8'($urandom), 1'($urandom_range(0, 3) != 0), 1'b0);
      end
    end
  endtask

  // ---------------- combinational-mode checks ----------------
  task automatic comb_table(input logic rst_level, input string tag);
    logic [1:0] ba;
    logic       ef;
    c1_nrst = rst_level;
    for (int i = 0; i < 4; i++) begin
      ba   = 2'(i);
      c1_b = ba[1];
      c1_a = ba[0];
      ef   = ba[1] ? ba[0] : 1'bz;
      #1;
      chk({tag, "_f"},  {7'b0, c1_f},  {7'b0, ef});
      chk({tag, "_oe"}, {7'b0, c1_oe}, {7'b0, ba[1]});
    end
  endtask

  task automatic comb_tests();
    logic [7:0] m_last;
    c1_nrst = 1'b1; c1_a = 1'b0; c1_b = 1'b0;
    c8_nrst = 1'b0; c8_a = 8'h00; c8_b = 1'b0;
    #1;
    chk("c8_rst_last", c8_last, 8'h00);
    c8_nrst = 1'b1;
    comb_table(1'b1, "c1_tt");
    comb_table(1'b0, "c1_tt_nrst0");
    // WIDTH=8: drive A5, capture it, release, verify it is held
    @(negedge clk);
    c8_a = 8'hA5; c8_b = 1'b1;
    #1;
    chk("c8_f_a5",  c8_f,          8'hA5);
    chk("c8_oe_on", {7'b0, c8_oe}, 8'h01);
    @(posedge clk); #1;
    chk("c8_last_a5", c8_last, 8'hA5);
    @(negedge clk);
    c8_b = 1'b0;
    #1;
    chk("c8_f_z",    c8_f,          8'hzz);
    chk("c8_oe_off", {7'b0, c8_oe}, 8'h00);
    @(posedge clk); #1;
    chk("c8_last_hold", c8_last, 8'hA5);
    // Random combinational traffic with a simple last-driven tracker
    m_last = 8'hA5;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      c8_a = 8'($urandom);
      c8_b = 1'($urandom);
      #1;
      chk("c8_rnd_f",  c8_f,          c8_b ? c8_a : 8'hzz);
      chk("c8_rnd_oe", {7'b0, c8_oe}, {7'b0, c8_b});
      if (c8_b) m_last = c8_a;
      @(posedge clk); #1;
      chk("c8_rnd_last", c8_last, m_last);
    end
    // Reset in combinational mode only clears last_q; drive continues
    @(negedge clk);
    c8_a = 8'h3C; c8_b = 1'b1; c8_nrst = 1'b0;
    #1;
    chk("c8_nrst_f",    c8_f,          8'h3C);
    chk("c8_nrst_oe",   {7'b0, c8_oe}, 8'h01);
    chk("c8_nrst_last", c8_last,       8'h00);
    c8_nrst = 1'b1;
  endtask

  initial begin
    fork
      comb_tests();
      reg_tests();
    join
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, 0 required", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
